// File: rtl/imem_load_controller.sv
// Purpose : sequences host uploads into the 16x16 instruction register file, then reads every
//           written word back and compares write/read checksums; owns the file's read port.
// Latency : back-to-back data gives cnt write cycles + cnt verify cycles + 1 check cycle.
// Backpressure: HOST_READY is high for the whole WRITE phase; host gaps simply stall the write pointer.
//
// Ports
//   CLOCK, RESET            rising-edge clock, async active-high reset
//   LOAD_START, LOAD_COUNT  session start pulse and word count (0..16, larger values clamp to 16)
//   HOST_VALID/READY/DATA   upload word stream
//   CPU_READ_SELECT         CPU fetch address, forwarded to READ_SELECT while idle
//   CPU_STALL, BUSY, DONE   session status; DONE pulses for one cycle at session end
//   READ_SELECT/IMEM_OUTPUT register file read port (combinational read data)
//   WRITE_SELECT/WRITE_ENABLE/IMEM_INPUT register file write port
//   VERIFY_ERR              checksum mismatch of the last session, sticky until the next start
module imem_load_controller #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4,
  parameter int DATA_W = 16
) (
  input  logic              CLOCK,
  input  logic              RESET,
  input  logic              LOAD_START,
  input  logic [ADDR_W:0]   LOAD_COUNT,
  input  logic              HOST_VALID,
  input  logic [DATA_W-1:0] HOST_DATA,
  output logic              HOST_READY,
  input  logic [ADDR_W-1:0] CPU_READ_SELECT,
  output logic              CPU_STALL,
  output logic [ADDR_W-1:0] READ_SELECT,
  input  logic [DATA_W-1:0] IMEM_OUTPUT,
  output logic [ADDR_W-1:0] WRITE_SELECT,
  output logic              WRITE_ENABLE,
  output logic [DATA_W-1:0] IMEM_INPUT,
  output logic              BUSY,
  output logic              DONE,
  output logic              VERIFY_ERR
);

  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  typedef enum logic [1:0] {IDLE, WRITE, VERIFY, CHECK} state_t;

  state_t              state, state_n;
  logic [CNT_W-1:0]    cnt;
  logic [ADDR_W-1:0]   waddr;
  logic [ADDR_W-1:0]   vaddr;
  logic [DATA_W-1:0]   wsum;
  logic [DATA_W-1:0]   rsum;
  logic                verify_err;
  logic                boot;

  logic [CNT_W-1:0]    cnt_in;
  logic                start;
  logic                handshake;
  logic                last_w;
  logic                last_v;

  assign cnt_in = (LOAD_COUNT > DEPTH_C) ? DEPTH_C : LOAD_COUNT;
  // The first edge after reset belongs to the file's BIOS preload, so starts wait for boot.
  assign start     = LOAD_START && boot;
  assign handshake = HOST_VALID && (state == WRITE);
  // cnt >= 1 whenever WRITE/VERIFY are active, so cnt-1 never underflows there.
  assign last_w    = ({1'b0, waddr} == (cnt - CNT_W'(1)));
  assign last_v    = ({1'b0, vaddr} == (cnt - CNT_W'(1)));

  assign VERIFY_ERR = verify_err;

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n      = state;
    HOST_READY   = 1'b0;
    WRITE_ENABLE = 1'b0;
    WRITE_SELECT = '0;
    IMEM_INPUT   = '0;
    READ_SELECT  = CPU_READ_SELECT;
    CPU_STALL    = 1'b1;
    BUSY         = 1'b1;
    DONE         = 1'b0;
    case (state)
      IDLE: begin
        CPU_STALL = 1'b0;
        BUSY      = 1'b0;
        if (start) begin
          state_n = (cnt_in == '0) ? CHECK : WRITE;
        end
      end
      WRITE: begin
        HOST_READY   = 1'b1;
        WRITE_ENABLE = HOST_VALID;
        WRITE_SELECT = waddr;
        IMEM_INPUT   = HOST_DATA;
        if (handshake && last_w) begin
          state_n = VERIFY;
        end
      end
      VERIFY: begin
        READ_SELECT = vaddr;
        if (last_v) begin
          state_n = CHECK;
        end
      end
      CHECK: begin
        DONE    = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      cnt        <= '0;
      waddr      <= '0;
      vaddr      <= '0;
      wsum       <= '0;
      rsum       <= '0;
      verify_err <= 1'b0;
      boot       <= 1'b0;
    end else begin
      boot <= 1'b1;
      case (state)
        IDLE: begin
          if (start) begin
            cnt        <= cnt_in;
            waddr      <= '0;
            vaddr      <= '0;
            wsum       <= '0;
            rsum       <= '0;
            verify_err <= 1'b0;
          end
        end
        WRITE: begin
          if (handshake) begin
            wsum <= wsum + HOST_DATA;
            // Hold on the last word so a full 16-word load never wraps the pointer.
            if (!last_w) begin
              waddr <= waddr + ADDR_W'(1);
            end
          end
        end
        VERIFY: begin
          rsum <= rsum + IMEM_OUTPUT;
          if (!last_v) begin
            vaddr <= vaddr + ADDR_W'(1);
          end
        end
        CHECK: begin
          verify_err <= (rsum != wsum);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_load_controller.sv
module tb_imem_load_controller;

  logic        CLOCK;
  logic        RESET;
  logic        LOAD_START;
  logic [4:0]  LOAD_COUNT;
  logic        HOST_VALID;
  logic [15:0] HOST_DATA;
  logic        HOST_READY;
  logic [3:0]  CPU_READ_SELECT;
  logic        CPU_STALL;
  logic [3:0]  READ_SELECT;
  logic [15:0] IMEM_OUTPUT;
  logic [3:0]  WRITE_SELECT;
  logic        WRITE_ENABLE;
  logic [15:0] IMEM_INPUT;
  logic        BUSY;
  logic        DONE;
  logic        VERIFY_ERR;

  imem_load_controller #(.DEPTH(16), .ADDR_W(4), .DATA_W(16)) dut (
    .CLOCK(CLOCK), .RESET(RESET), .LOAD_START(LOAD_START), .LOAD_COUNT(LOAD_COUNT),
    .HOST_VALID(HOST_VALID), .HOST_DATA(HOST_DATA), .HOST_READY(HOST_READY),
    .CPU_READ_SELECT(CPU_READ_SELECT), .CPU_STALL(CPU_STALL), .READ_SELECT(READ_SELECT),
    .IMEM_OUTPUT(IMEM_OUTPUT), .WRITE_SELECT(WRITE_SELECT), .WRITE_ENABLE(WRITE_ENABLE),
    .IMEM_INPUT(IMEM_INPUT), .BUSY(BUSY), .DONE(DONE), .VERIFY_ERR(VERIFY_ERR)
  );

  initial begin
    CLOCK = 1'b0;
    forever #5 CLOCK = ~CLOCK;
  end

  // Register file model: BIOS preload on the first edge out of reset, then host writes.
  logic [15:0] mem [16];
  logic        bios_done = 1'b0;
  logic        corrupt   = 1'b0;
  int          wr_count   = 0;
  int          done_count = 0;

  always @(posedge CLOCK) begin
    if (RESET) begin
      bios_done <= 1'b0;
    end else if (!bios_done) begin
      for (int i = 0; i < 16; i++) mem[i] <= 16'hB000 + 16'(i);
      bios_done <= 1'b1;
    end
    if (WRITE_ENABLE) begin
      mem[WRITE_SELECT] <= IMEM_INPUT;
      wr_count <= wr_count + 1;
    end
    if (DONE) done_count <= done_count + 1;
  end

  assign IMEM_OUTPUT = mem[READ_SELECT] ^ {15'b0, (corrupt && READ_SELECT == 4'd1)};

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLOCK);
    #1;
  endtask

  int base;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    RESET = 1'b1; LOAD_START = 1'b0; LOAD_COUNT = '0; HOST_VALID = 1'b0;
    HOST_DATA = '0; CPU_READ_SELECT = '0;

    // 1. Reset values, boot edge ignores LOAD_START
    #2;
    check("rst_ctl", {BUSY, DONE, VERIFY_ERR, HOST_READY, CPU_STALL, WRITE_ENABLE}, 32'h0);
    check("rst_sel", {WRITE_SELECT, READ_SELECT}, 32'h0);
    check("rst_imem_in", IMEM_INPUT, 32'h0);
    tick();
    RESET = 1'b0; LOAD_START = 1'b1; LOAD_COUNT = 5'd3; HOST_VALID = 1'b1; HOST_DATA = 16'hDEAD;
    tick();
    LOAD_START = 1'b0;
    #1;
    check("boot_busy", {BUSY, HOST_READY, WRITE_ENABLE, CPU_STALL}, 32'h0);
    tick();
    check("boot_no_wr", wr_count, 0);
    check("boot_idle", BUSY, 0);

    // 2. cnt=3 back-to-back
    HOST_VALID = 1'b0; CPU_READ_SELECT = 4'd7; LOAD_START = 1'b1; LOAD_COUNT = 5'd3;
    tick();
    LOAD_START = 1'b0; HOST_VALID = 1'b1; HOST_DATA = 16'h1234;
    #1;
    check("t2_w0_ctl", {BUSY, CPU_STALL, HOST_READY, WRITE_ENABLE}, 32'hF);
    check("t2_w0_sel", WRITE_SELECT, 0);
    check("t2_w0_dat", IMEM_INPUT, 32'h1234);
    tick();
    HOST_DATA = 16'hABCD;
    #1;
    check("t2_w1_sel", {WRITE_ENABLE, WRITE_SELECT}, {27'h0, 1'b1, 4'd1});
    tick();
    HOST_DATA = 16'h0F0F;
    #1;
    check("t2_w2_sel", {WRITE_ENABLE, WRITE_SELECT}, {27'h0, 1'b1, 4'd2});
    tick();
    HOST_VALID = 1'b0;
    #1;
    check("t2_v0_rsel", READ_SELECT, 0);
    check("t2_v0_ctl", {BUSY, HOST_READY, WRITE_ENABLE, DONE}, 32'h8);
    tick(); #1;
    check("t2_v1_rsel", READ_SELECT, 1);
    tick(); #1;
    check("t2_v2_rsel", READ_SELECT, 2);
    check("t2_v2_nodone", DONE, 0);
    tick(); #1;
    check("t2_done_c7", {DONE, BUSY}, 32'h3);
    tick(); #1;
    check("t2_after", {DONE, BUSY, CPU_STALL, VERIFY_ERR}, 32'h0);
    check("t2_rsel_cpu", READ_SELECT, 7);
    check("t2_wr_count", wr_count, 3);
    check("t2_mem", {mem[0], mem[2]}, 32'h1234_0F0F);
    check("t2_mem1", mem[1], 32'hABCD);

    // 3. cnt=2 with a 3-cycle gap
    base = wr_count;
    LOAD_START = 1'b1; LOAD_COUNT = 5'd2;
    tick();
    LOAD_START = 1'b0; HOST_VALID = 1'b1; HOST_DATA = 16'h5555;
    #1;
    check("t3_w0", {WRITE_ENABLE, WRITE_SELECT}, {27'h0, 1'b1, 4'd0});
    for (int k = 0; k < 3; k++) begin
      tick();
      HOST_VALID = 1'b0;
      #1;
      check("t3_gap", {HOST_READY, WRITE_ENABLE, WRITE_SELECT}, {26'h0, 2'b10, 4'd1});
    end
    tick();
    HOST_VALID = 1'b1; HOST_DATA = 16'hAAAA;
    #1;
    check("t3_w1", {WRITE_ENABLE, WRITE_SELECT}, {27'h0, 1'b1, 4'd1});
    tick();
    HOST_VALID = 1'b0;
    #1;
    check("t3_v0", {BUSY, HOST_READY, READ_SELECT}, {26'h0, 2'b10, 4'd0});
    tick(); #1;
    check("t3_v1", READ_SELECT, 1);
    tick(); #1;
    check("t3_done", DONE, 1);
    tick(); #1;
    check("t3_wr_count", wr_count - base, 2);
    check("t3_mem", {mem[0], mem[1]}, 32'h5555_AAAA);
    check("t3_err", VERIFY_ERR, 0);

    // 4. Full load, LOAD_COUNT above 16 clamps to 16
    base = wr_count;
    CPU_READ_SELECT = 4'd0; LOAD_START = 1'b1; LOAD_COUNT = 5'd31;
    tick();
    LOAD_START = 1'b0;
    for (int i = 0; i < 16; i++) begin
      HOST_VALID = 1'b1; HOST_DATA = 16'h1000 + 16'(i) * 16'h0101;
      #1;
      check("t4_wsel", {WRITE_ENABLE, WRITE_SELECT}, {27'h0, 1'b1, 4'(i)});
      tick();
    end
    HOST_VALID = 1'b0;
    for (int i = 0; i < 16; i++) begin
      #1;
      check("t4_rsel", {WRITE_ENABLE, READ_SELECT}, {28'h0, 4'(i)});
      tick();
    end
    #1;
    check("t4_done", DONE, 1);
    tick();
    CPU_READ_SELECT = 4'd9;
    #1;
    check("t4_rsel_cpu", READ_SELECT, 9);
    check("t4_word9", IMEM_OUTPUT, 32'h1909);
    check("t4_word15", mem[15], 32'h1F0F);
    check("t4_stall", {CPU_STALL, BUSY, VERIFY_ERR}, 0);
    check("t4_wr_count", wr_count - base, 16);

    // 5. Corrupted read at address 1 flags VERIFY_ERR
    CPU_READ_SELECT = 4'd0; corrupt = 1'b1; LOAD_START = 1'b1; LOAD_COUNT = 5'd3;
    tick();
    LOAD_START = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      HOST_VALID = 1'b1; HOST_DATA = 16'(i);
      tick();
    end
    HOST_VALID = 1'b0;
    for (int t = 0; t < 40; t++) begin
      #1;
      if (DONE) break;
      tick();
    end
    check("t5_done_seen", DONE, 1);
    tick(); #1;
    check("t5_err", VERIFY_ERR, 1);
    tick(); #1;
    check("t5_err_sticky", VERIFY_ERR, 1);
    corrupt = 1'b0; LOAD_START = 1'b1; LOAD_COUNT = 5'd1;
    tick();
    LOAD_START = 1'b0; HOST_VALID = 1'b1; HOST_DATA = 16'h7777;
    #1;
    check("t5_err_clr", VERIFY_ERR, 0);
    tick();
    HOST_VALID = 1'b0;
    tick(); #1;
    check("t5_cnt1_done", DONE, 1);
    tick(); #1;
    check("t5_cnt1_ok", {VERIFY_ERR, BUSY}, 0);

    // 6a. cnt=0: DONE on the next cycle, no writes
    base = wr_count;
    LOAD_START = 1'b1; LOAD_COUNT = 5'd0;
    tick();
    LOAD_START = 1'b0;
    #1;
    check("t6_zero_done", {DONE, BUSY, WRITE_ENABLE, HOST_READY}, 32'hC);
    tick(); #1;
    check("t6_zero_idle", {DONE, BUSY, VERIFY_ERR}, 0);
    check("t6_zero_nowr", wr_count - base, 0);

    // 6b. Reset mid-WRITE after two words
    base = done_count;
    LOAD_START = 1'b1; LOAD_COUNT = 5'd4;
    tick();
    LOAD_START = 1'b0; HOST_VALID = 1'b1; HOST_DATA = 16'hC001;
    tick();
    HOST_DATA = 16'hC002;
    tick();
    HOST_DATA = 16'hC003;
    #1;
    check("t6_mid_write", {WRITE_ENABLE, WRITE_SELECT}, {27'h0, 1'b1, 4'd2});
    RESET = 1'b1;
    #1;
    check("t6_rst_ctl", {BUSY, DONE, VERIFY_ERR, HOST_READY, CPU_STALL, WRITE_ENABLE}, 0);
    check("t6_rst_sel", {WRITE_SELECT, READ_SELECT, IMEM_INPUT}, 0);
    tick();
    tick();
    check("t6_rst_nodone", done_count - base, 0);
    RESET = 1'b0; HOST_VALID = 1'b0;
    tick();
    LOAD_START = 1'b1; LOAD_COUNT = 5'd2;
    tick();
    LOAD_START = 1'b0; HOST_VALID = 1'b1; HOST_DATA = 16'h1111;
    tick();
    HOST_DATA = 16'h2222;
    tick();
    HOST_VALID = 1'b0;
    tick();
    tick(); #1;
    check("t6_fresh_done", DONE, 1);
    tick(); #1;
    check("t6_fresh_err", {VERIFY_ERR, BUSY}, 0);
    check("t6_fresh_mem", {mem[0], mem[1]}, 32'h1111_2222);
    check("t6_fresh_bios", mem[2], 32'hB002);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
